// File: rtl/lcd_pkg.sv
// Shared definitions for the front-panel instruction entry path.
// Opcodes, switch-word field positions, capture FSM encoding and the field normaliser.
package lcd_pkg;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_DPL  = 3'b111;

  localparam int unsigned SW_W    = 14;
  localparam int unsigned OPC_MSB = 13;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned REG_MSB = 10;
  localparam int unsigned REG_LSB = 7;
  localparam int unsigned IMM_MSB = 6;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [6:0] IMM_NEG_ZERO = 7'b1000000;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StWaitRel
  } cap_state_e;

  typedef struct packed {
    logic [2:0] opcode;
    logic [3:0] endreg;
    logic [6:0] imm;
  } instr_t;

  // Split the switch word; fold sign-magnitude -0 to +0 and blank operands of CLR.
  function automatic instr_t decode_sw(input logic [SW_W-1:0] sw);
    instr_t f;
    f.opcode = sw[OPC_MSB:OPC_LSB];
    f.endreg = sw[REG_MSB:REG_LSB];
    f.imm    = sw[IMM_MSB:IMM_LSB];
    if (f.imm == IMM_NEG_ZERO) f.imm = '0;
    if (f.opcode == OP_CLR) begin
      f.endreg = '0;
      f.imm    = '0;
    end
    return f;
  endfunction

endpackage

// File: rtl/instr_capture_if.sv
// Front-panel input and LCD-facing instruction bundle.
// slave = capture stage side, master = panel/LCD side.
interface instr_capture_if;
  import lcd_pkg::*;

  logic            key_n;
  logic [SW_W-1:0] sw;
  logic [2:0]      opcode;
  logic [3:0]      endreg;
  logic [6:0]      imm;
  logic            valid;
  logic            busy;
  logic [7:0]      count;

  modport slave (
    input  key_n,
    input  sw,
    output opcode,
    output endreg,
    output imm,
    output valid,
    output busy,
    output count
  );

  modport master (
    output key_n,
    output sw,
    input  opcode,
    input  endreg,
    input  imm,
    input  valid,
    input  busy,
    input  count
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button synchroniser and level debouncer.
// o_press strobes on the same edge that o_key_stable falls.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_key_stable,
  output logic o_press
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic            r_key_meta;
  logic            r_key_sync;
  logic            r_key_stable;
  logic [CntW-1:0] r_cnt;
  logic            w_settled;

  assign w_settled = (r_key_sync != r_key_stable) && (r_cnt == CntMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_meta   <= 1'b1;
      r_key_sync   <= 1'b1;
      r_key_stable <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_key_meta <= i_key_n;
      r_key_sync <= r_key_meta;
      if (r_key_sync == r_key_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_key_stable <= r_key_sync;
        r_cnt        <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_key_stable = r_key_stable;
  assign o_press      = w_settled & ~r_key_sync;

endmodule

// File: rtl/instr_capture.sv
// Instruction entry stage: one debounced press latches one normalised switch word,
// then presses are locked out until the hold window ends and the button is released.
module instr_capture
  import lcd_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned HOLD_CYCLES = 5_000_000
) (
  input logic              clk,
  input logic              rst,
  instr_capture_if.slave   bus
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  // The valid cycle is hold count 0; counting to HOLD_CYCLES keeps busy for
  // HOLD_CYCLES full cycles after valid.
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);

  logic [SW_W-1:0]  r_sw_meta;
  logic [SW_W-1:0]  r_sw_sync;
  logic             w_key_stable;
  logic             w_press;
  cap_state_e       r_state;
  logic [HoldW-1:0] r_hold_cnt;
  instr_t           r_instr;
  logic             r_valid;
  logic             r_busy;
  logic [7:0]       r_count;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .clk          (clk),
    .rst          (rst),
    .i_key_n      (bus.key_n),
    .o_key_stable (w_key_stable),
    .o_press      (w_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= bus.sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_hold_cnt <= '0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_press) begin
            r_instr    <= decode_sw(r_sw_sync);
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
            r_count    <= r_count + 8'd1;
            r_hold_cnt <= '0;
            r_state    <= StHold;
          end
        end
        StHold: begin
          if (r_hold_cnt == HoldMax) begin
            if (w_key_stable) begin
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end else begin
              r_state <= StWaitRel;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HoldW'(1);
          end
        end
        StWaitRel: begin
          if (w_key_stable) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.opcode = r_instr.opcode;
  assign bus.endreg = r_instr.endreg;
  assign bus.imm    = r_instr.imm;
  assign bus.valid  = r_valid;
  assign bus.busy   = r_busy;
  assign bus.count  = r_count;

endmodule

// File: tb/tb_instr_capture.sv
// Scoreboard bench for instr_capture with short debounce and hold windows.
module tb_instr_capture;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 10;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] rg;
    logic [6:0] im;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_capture_if bus ();

  instr_capture #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       sb_q[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         n_valid   = 0;
  logic [7:0] exp_count = 8'd0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [13:0] s, input logic [7:0] c);
    exp_t e;
    e.op  = s[13:11];
    e.rg  = s[10:7];
    e.im  = s[6:0];
    e.cnt = c;
    if (e.im == 7'h40) e.im = 7'h00;
    if (e.op == 3'b110) begin
      e.rg = 4'h0;
      e.im = 7'h00;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.valid) begin
      exp_t e;
      n_valid++;
      if (sb_q.size() == 0) begin
        check_eq("valid_expected", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_opcode", 32'(bus.opcode), 32'(e.op));
        check_eq("sb_endreg", 32'(bus.endreg), 32'(e.rg));
        check_eq("sb_imm", 32'(bus.imm), 32'(e.im));
        check_eq("sb_count", 32'(bus.count), 32'(e.cnt));
        check_eq("sb_busy", 32'(bus.busy), 32'd1);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_opcode"}, 32'(bus.opcode), 32'd0);
    check_eq({tag, "_endreg"}, 32'(bus.endreg), 32'd0);
    check_eq({tag, "_imm"}, 32'(bus.imm), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_count"}, 32'(bus.count), 32'd0);
  endtask

  task automatic wait_idle();
    int k;
    repeat (DEB + 4) @(negedge clk);
    for (k = 0; k < 300 && bus.busy; k++) @(negedge clk);
    check_eq("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_valid(input int nv0, input string tag);
    for (int k = 0; k < 60 && n_valid == nv0; k++) @(negedge clk);
    check_eq(tag, 32'(n_valid - nv0), 32'd1);
  endtask

  // Accepted press: key held low for 'held' cycles; reports busy cycles after valid.
  task automatic press(input logic [13:0] s, input int held, output int busy_after);
    bit seen;
    bit done;
    bus.sw = s;
    repeat (3) @(negedge clk);
    exp_count++;
    sb_q.push_back(model(s, exp_count));
    seen       = 1'b0;
    done       = 1'b0;
    busy_after = 0;
    bus.key_n  = 1'b0;
    for (int t = 1; t < 400 && !done; t++) begin
      @(negedge clk);
      if (t == held) bus.key_n = 1'b1;
      if (bus.valid) seen = 1'b1;
      else if (seen && bus.busy) busy_after++;
      if (seen && !bus.busy && t > held) done = 1'b1;
    end
    check_eq("press_done", 32'(done), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int         ba;
    int         nv0;
    int         lat;
    int         n;
    exp_t       a_exp;
    logic [13:0] s;

    bus.key_n = 1'b1;
    bus.sw    = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check_reset_outputs("idle");
    check_eq("idle_no_valid", 32'(n_valid), 32'd0);

    // Long press: one instruction, busy spans the hold window.
    press(14'b001_0101_0000011, 20, ba);
    check_eq("first_count", 32'(bus.count), 32'd1);
    check_eq("first_opcode", 32'(bus.opcode), 32'd1);
    check_eq("first_busy_len", 32'(ba >= HOLD), 32'd1);
    check_eq("first_one_valid", 32'(n_valid), 32'd1);

    // Bouncing key: 2-cycle pulses, then settle low.
    bus.sw = 14'b011_0010_0101010;
    repeat (3) @(negedge clk);
    exp_count++;
    sb_q.push_back(model(14'b011_0010_0101010, exp_count));
    nv0 = n_valid;
    for (int i = 0; i < 15; i++) begin
      bus.key_n = ~bus.key_n;
      if (i < 14) repeat (2) @(negedge clk);
    end
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) lat = k;
    end
    check_eq("bounce_latency", 32'(lat), 32'(DEB + 2));
    repeat (10) @(negedge clk);
    bus.key_n = 1'b1;
    wait_idle();
    check_eq("bounce_one_valid", 32'(n_valid - nv0), 32'd1);

    // Second press inside the hold window is dropped; switch moves are ignored.
    s = 14'b101_0110_0001111;
    bus.sw = s;
    repeat (3) @(negedge clk);
    exp_count++;
    a_exp = model(s, exp_count);
    sb_q.push_back(a_exp);
    nv0 = n_valid;
    bus.key_n = 1'b0;
    repeat (4) @(negedge clk);
    bus.key_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.key_n = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("held_busy", 32'(bus.busy), 32'd1);
    bus.sw = 14'b111_0001_0000001;
    repeat (5) @(negedge clk);
    bus.key_n = 1'b1;
    wait_idle();
    check_eq("drop_one_valid", 32'(n_valid - nv0), 32'd1);
    check_eq("drop_opcode", 32'(bus.opcode), 32'(a_exp.op));
    check_eq("drop_endreg", 32'(bus.endreg), 32'(a_exp.rg));
    check_eq("drop_imm", 32'(bus.imm), 32'(a_exp.im));
    check_eq("drop_count", 32'(bus.count), 32'(exp_count));
    press(14'b111_0001_0000001, 6, ba);
    check_eq("after_drop_opcode", 32'(bus.opcode), 32'd7);

    // Normalisation: negative zero and CLR.
    press(14'b010_0011_1000000, 6, ba);
    check_eq("negzero_imm", 32'(bus.imm), 32'd0);
    check_eq("short_busy_len", 32'(ba >= HOLD), 32'd1);
    press(14'b110_1111_1111111, 6, ba);
    check_eq("clr_endreg", 32'(bus.endreg), 32'd0);
    check_eq("clr_imm", 32'(bus.imm), 32'd0);

    // Drive the counter through 255 -> 0.
    n = 256 - int'(exp_count);
    for (int i = 0; i < n; i++) press(14'($urandom), 6, ba);
    check_eq("count_wrap", 32'(bus.count), 32'd0);

    // Reset mid-hold with the key held through reset release.
    s = 14'b100_1001_0010110;
    bus.sw = s;
    repeat (3) @(negedge clk);
    exp_count++;
    sb_q.push_back(model(s, exp_count));
    nv0 = n_valid;
    bus.key_n = 1'b0;
    wait_valid(nv0, "prereset_valid");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midhold_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_count = 8'd1;
    sb_q.push_back(model(s, exp_count));
    nv0 = n_valid;
    wait_valid(nv0, "postreset_valid");
    repeat (20) @(negedge clk);
    check_eq("postreset_one_valid", 32'(n_valid - nv0), 32'd1);
    bus.key_n = 1'b1;
    wait_idle();

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
